// File: rtl/hdmi_pattern_gen.sv
// Free-running raster timing generator with synthetic test patterns, emitting
// the hdmi_pack bundle {clk, hsync, vsync, de, r, g, b, x, y}.
module hdmi_pattern_gen #(
    parameter int   H_ACT  = 1280,
    parameter int   H_FP   = 110,
    parameter int   H_SYNC = 40,
    parameter int   H_BP   = 220,
    parameter int   V_ACT  = 720,
    parameter int   V_FP   = 5,
    parameter int   V_SYNC = 5,
    parameter int   V_BP   = 20,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1,
    localparam int  XW     = $clog2(H_ACT),
    localparam int  YW     = $clog2(V_ACT),
    localparam int  PACK_W = 28 + XW + YW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        mode,
    input  logic [23:0]       solid_rgb,
    output logic [PACK_W-1:0] o_pack,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
    localparam logic [HW-1:0] H_SS_C   = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] H_SE_C   = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] BAR_W_C  = HW'(H_ACT / 8);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
    localparam logic [VW-1:0] V_SS_C   = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] V_SE_C   = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_r, h_nxt_s, bar_q_s;
    logic [VW-1:0] v_cnt_r, v_nxt_s;
    logic          h_last_s, v_last_s, wrap_s;
    logic [7:0]    frame_cnt_r;
    logic [1:0]    mode_sh_r;
    logic [23:0]   col_sh_r;
    logic          de_s, hs_s, vs_s;
    logic [2:0]    bar_idx_s;
    logic [7:0]    hx8_s, vy8_s;
    logic [23:0]   pix_s, rgb_s;

    logic          hsync_r, vsync_r, de_r, frame_start_r;
    logic [23:0]   rgb_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    // Counter next-state and wrap detection.
    always_comb begin
        h_last_s = (h_cnt_r == H_LAST_C);
        v_last_s = (v_cnt_r == V_LAST_C);
        wrap_s   = h_last_s && v_last_s;
        if (h_last_s) begin
            h_nxt_s = {HW{1'b0}};
            if (v_last_s) begin
                v_nxt_s = {VW{1'b0}};
            end else begin
                v_nxt_s = v_cnt_r + VW'(1);
            end
        end else begin
            h_nxt_s = h_cnt_r + HW'(1);
            v_nxt_s = v_cnt_r;
        end
    end

    // Sync/active decode and pattern selection from the current counters.
    always_comb begin
        de_s  = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        hs_s  = ((h_cnt_r >= H_SS_C) && (h_cnt_r < H_SE_C)) ? HS_POL : ~HS_POL;
        vs_s  = ((v_cnt_r >= V_SS_C) && (v_cnt_r < V_SE_C)) ? VS_POL : ~VS_POL;
        hx8_s = 8'(h_cnt_r);
        vy8_s = 8'(v_cnt_r);
        bar_q_s = h_cnt_r / BAR_W_C;
        if (bar_q_s > HW'(7)) begin
            bar_idx_s = 3'd7;
        end else begin
            bar_idx_s = bar_q_s[2:0];
        end
        case (mode_sh_r)
            2'd0:    pix_s = bar_colour(bar_idx_s);
            2'd1:    pix_s = {hx8_s, vy8_s, frame_cnt_r};
            2'd2:    pix_s = col_sh_r;
            2'd3:    pix_s = (hx8_s[5] ^ vy8_s[5]) ? 24'hFFFFFF : 24'h000000;
            default: pix_s = 24'h000000;
        endcase
        if (de_s) begin
            rgb_s = pix_s;
        end else begin
            rgb_s = 24'h000000;
        end
    end

    // Raster counters, frame counter and per-frame shadow of the pattern controls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt_r     <= {HW{1'b0}};
            v_cnt_r     <= {VW{1'b0}};
            frame_cnt_r <= 8'd0;
            mode_sh_r   <= 2'd0;
            col_sh_r    <= 24'h000000;
        end else begin
            h_cnt_r <= h_nxt_s;
            v_cnt_r <= v_nxt_s;
            if (wrap_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
                mode_sh_r   <= mode;
                col_sh_r    <= solid_rgb;
            end
        end
    end

    // Registered pack fields; they describe the counter state of the previous cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            de_r          <= 1'b0;
            rgb_r         <= 24'h000000;
            x_r           <= {XW{1'b0}};
            y_r           <= {YW{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            hsync_r       <= hs_s;
            vsync_r       <= vs_s;
            de_r          <= de_s;
            rgb_r         <= rgb_s;
            x_r           <= de_s ? h_cnt_r[XW-1:0] : {XW{1'b0}};
            y_r           <= de_s ? v_cnt_r[YW-1:0] : {YW{1'b0}};
            frame_start_r <= de_s && (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
        end
    end

    assign o_pack      = {clk, hsync_r, vsync_r, de_r, rgb_r, x_r, y_r};
    assign frame_start = frame_start_r;

endmodule
